multicore_data_arbiter: RTL and testbench
=========================================

MULTICORE_DATA_ARBITER -- requirements
Module: multicore_data_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4, number of core request channels, legal 1..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 16, data address width.
REQ-004 The block SHALL have parameter MEM_LATENCY, default 1, cycles from memory command to valid mem_rdata, legal 1..4.
REQ-005 The block SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-006 The block SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have port core_control  input  2*NUM_CORES  per-core command, slice i = bits [2i+1:2i]; 00 idle, 01 read, 10 write, 11 reserved.
REQ-008 The block SHALL have port core_addr  input  NUM_CORES*ADDR_WIDTH  per-core address, slice i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 The block SHALL have port core_wdata  input  NUM_CORES*DATA_WIDTH  per-core write data.
REQ-010 The block SHALL have port core_rdata  output  NUM_CORES*DATA_WIDTH  per-core registered read data.
REQ-011 The block SHALL have port core_ready  output  NUM_CORES  per-core one-cycle completion pulse.
REQ-012 The block SHALL have port mem_control  output  2  command to the shared data memory, same encoding as core_control.
REQ-013 The block SHALL have port mem_addr  output  ADDR_WIDTH, and port mem_wdata  output  DATA_WIDTH, to the memory.
REQ-014 The block SHALL have port mem_rdata  input  DATA_WIDTH  memory read data.
REQ-015 The block SHALL have port grant_id  output  max(1,$clog2(NUM_CORES))  index of the core currently being served.

Function
REQ-016 A core SHALL be requesting when its core_control slice is 01 or 10; 11 and 00 SHALL be ignored.
REQ-017 The block SHALL implement states IDLE, ACCESS, WAIT, RESP.
REQ-018 In IDLE with >=1 requester, the block SHALL grant the first requester found searching upward from last_grant+1 (mod NUM_CORES), latch its op, addr and wdata, set grant_id, and go to ACCESS; with no requester it SHALL stay in IDLE.
REQ-019 In ACCESS (exactly one cycle), mem_control SHALL equal the latched op, with mem_addr/mem_wdata the latched values; mem_control SHALL be 00 in every other state.
REQ-020 WAIT SHALL last exactly MEM_LATENCY cycles, counted by a down-counter loaded on entry.
REQ-021 In RESP (one cycle), core_ready[grant_id] SHALL be 1, all other ready bits 0; for a read, core_rdata slice grant_id SHALL have been loaded with mem_rdata sampled at the last WAIT edge; for a write, core_rdata SHALL be unchanged.
REQ-022 On leaving RESP, last_grant SHALL become grant_id and state SHALL return to IDLE.
REQ-023 Latency: request visible in IDLE cycle 0 -> ACCESS cycle 1 -> WAIT cycles 2..1+MEM_LATENCY -> core_ready high in cycle 2+MEM_LATENCY; next grant earliest in cycle 3+MEM_LATENCY.
REQ-024 Requests changing while not in IDLE SHALL not affect the transaction in progress (latched values only).
REQ-025 A core SHALL hold its command until core_ready; the arbiter SHALL re-sample it in IDLE and treat a still-asserted command as a new request.
REQ-026 Fairness: a continuously requesting core SHALL be granted within NUM_CORES transactions.
REQ-027 Non-granted core_rdata slices SHALL hold their values indefinitely.
REQ-028 NUM_CORES=1 SHALL degenerate to a single-channel pass-through with grant_id constant 0.

Reset
REQ-029 With reset_n low at a clock edge: state IDLE, last_grant NUM_CORES-1, grant_id 0, mem_control 00, mem_addr 0, mem_wdata 0, core_ready all 0, core_rdata all 0, WAIT counter 0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no core_ready pulse; first grant after reset release SHALL favour core 0.

Verification
REQ-031 Single read: NUM_CORES=4, MEM_LATENCY=1, core 2 reads addr 0x0010, memory returns 0xBEEF -> mem_control 01 in cycle 1, core_ready[2] in cycle 3, core_rdata slice 2 = 0xBEEF.
REQ-032 Write: core 0 writes 0x1234 to 0x0005 -> one ACCESS cycle with mem_control 10, mem_addr 0x0005, mem_wdata 0x1234; core_ready[0] pulse; core_rdata unchanged.
REQ-033 Round robin: all 4 cores request continuously after reset -> grant order 0,1,2,3,0; each core_ready exactly one cycle wide.
REQ-034 Latency sweep: MEM_LATENCY=4 single read -> core_ready in cycle 6, mem_rdata sampled at cycle-5 edge.
REQ-035 Reset mid-op: reset_n low during WAIT -> no core_ready, all outputs at REQ-029 values; next grant to lowest-index requester.
REQ-036 Reserved/churn: core 1 drives 11 and core 3 changes addr during WAIT -> core 1 never granted, core 3 transaction uses latched addr.

Source files
------------

// File: rtl/multicore_data_arbiter.sv
// multicore_data_arbiter
//   Round-robin arbiter that lets NUM_CORES cores share one data memory port.
//   One transaction is in flight at a time: IDLE -> ACCESS -> WAIT -> RESP.
//
// Ports
//   clock, reset_n     single clock, synchronous active-low reset
//   core_control       2 bits per core: 00 idle, 01 read, 10 write, 11 ignored
//   core_addr          ADDR_WIDTH bits per core
//   core_wdata         DATA_WIDTH bits per core
//   core_rdata         DATA_WIDTH bits per core, registered read data
//   core_ready         per-core one-cycle completion pulse
//   mem_control        command to the memory (non-zero only in ACCESS)
//   mem_addr/mem_wdata latched address / write data of the current transaction
//   mem_rdata          memory read data, valid MEM_LATENCY cycles after command
//   grant_id           index of the core currently being served
//
// state  | meaning
// IDLE   | look for a requester, latch its command on grant
// ACCESS | drive the latched command to memory for one cycle
// WAIT   | count MEM_LATENCY cycles; capture read data on the last one
// RESP   | pulse core_ready of the granted core, then update last_grant
module multicore_data_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1,
  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [2*NUM_CORES-1:0]           core_control,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wdata,
  output logic [NUM_CORES*DATA_WIDTH-1:0]  core_rdata,
  output logic [NUM_CORES-1:0]             core_ready,
  output logic [1:0]                       mem_control,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [GW-1:0]                    grant_id
);

  localparam int CW = 3;
  localparam logic [1:0] OP_READ = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [GW-1:0]                   last_grant_q, last_grant_d;
  logic [GW-1:0]                   grant_q, grant_d;
  logic [1:0]                      op_q, op_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_CORES*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_CORES-1:0] req;
  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic [GW-1:0]        cand_idx;
  int                   cand;

  // 01 and 10 are the only real commands; 11 behaves like idle.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req[i] = core_control[2*i] ^ core_control[2*i+1];
    end
  end

  // Search upward starting just after the last served core.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand     = (int'(last_grant_q) + 1 + k) % NUM_CORES;
      cand_idx = GW'(cand);
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    mem_control  = 2'b00;
    core_ready   = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          op_d    = core_control[2*pick_idx +: 2];
          addr_d  = core_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = core_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_control = op_q;
        cnt_d       = CW'(MEM_LATENCY - 1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // last WAIT cycle: memory data is valid now
          if (op_q == OP_READ) begin
            rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        core_ready[grant_q] = 1'b1;
        last_grant_d        = grant_q;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_CORES - 1);
      grant_q      <= '0;
      op_q         <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign grant_id   = grant_q;
  assign core_rdata = rdata_q;

endmodule

// File: tb/tb_multicore_data_arbiter.sv
// Testbench for multicore_data_arbiter: a latency-1 instance carries the
// functional scenarios, a latency-4 instance covers the long-latency read.
module tb_multicore_data_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk;
  logic reset_n;

  logic [2*N-1:0]  core_control;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N*DW-1:0] core_rdata;
  logic [N-1:0]    core_ready;
  logic [1:0]      mem_control;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      grant_id;

  logic [2*N-1:0]  ctl4;
  logic [N*AW-1:0] a4;
  logic [N*DW-1:0] w4;
  logic [N*DW-1:0] rd4;
  logic [N-1:0]    rdy4;
  logic [1:0]      mc4;
  logic [AW-1:0]   ma4;
  logic [DW-1:0]   mw4;
  logic [DW-1:0]   mr4;
  logic [1:0]      gid4;

  multicore_data_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut (
    .clock(clk), .reset_n(reset_n),
    .core_control(core_control), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready),
    .mem_control(mem_control), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id)
  );

  multicore_data_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(4)) dut4 (
    .clock(clk), .reset_n(reset_n),
    .core_control(ctl4), .core_addr(a4), .core_wdata(w4),
    .core_rdata(rd4), .core_ready(rdy4),
    .mem_control(mc4), .mem_addr(ma4), .mem_wdata(mw4),
    .mem_rdata(mr4), .grant_id(gid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_seen <= !reset_n;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] mfn(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : {~a[7:0], a[7:0]};
  endfunction

  // Memory models: read data valid exactly MEM_LATENCY cycles after the
  // command and only for one cycle, otherwise a marker value.
  always @(posedge clk) mem_rdata <= (mem_control == 2'b01) ? mfn(mem_addr) : 16'hDEAD;

  logic [15:0] pipe4 [4];
  always @(posedge clk) begin
    pipe4[0] <= (mc4 == 2'b01) ? mfn(ma4) : 16'hDEAD;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign mr4 = pipe4[3];

  typedef struct {
    int         core;
    logic [1:0] op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int         req_cyc;
    int         acc_cyc;
    bit         abort;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];

  function automatic exp_t mk(input int c, input logic [1:0] op, input logic [15:0] a,
                              input logic [15:0] d, input int rc, input bit ab);
    exp_t e;
    e.core = c; e.op = op; e.addr = a; e.wdata = d; e.rdata = mfn(a);
    e.req_cyc = rc; e.acc_cyc = -1; e.abort = ab;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  logic [N*DW-1:0] shadow  = '0;
  logic [N*DW-1:0] shadow4 = '0;
  logic [N-1:0]    prev_ready = '0;
  exp_t            em;

  always @(negedge clk) begin
    if (!reset_n) begin
      while (q.size() > 0 && q[0].abort) void'(q.pop_front());
      shadow     = '0;
      shadow4    = '0;
      prev_ready = '0;
      if (rst_seen) begin
        chk("rst_mem_control", {62'd0, mem_control}, 64'd0);
        chk("rst_mem_addr",    {48'd0, mem_addr},    64'd0);
        chk("rst_mem_wdata",   {48'd0, mem_wdata},   64'd0);
        chk("rst_core_ready",  {60'd0, core_ready},  64'd0);
        chk("rst_core_rdata",  core_rdata,           64'd0);
        chk("rst_grant_id",    {62'd0, grant_id},    64'd0);
        chk("rst4_outputs",    {mc4, gid4, rdy4, ma4, mw4}, 64'd0);
        chk("rst4_core_rdata", rd4,                  64'd0);
      end
    end else begin
      if (mem_control != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_access", {62'd0, mem_control}, 64'd0);
        end else begin
          chk("single_access", 64'(q[0].acc_cyc >= 0), 64'd0);
          q[0].acc_cyc = cyc;
          chk("access_op",    {62'd0, mem_control}, {62'd0, q[0].op});
          chk("access_addr",  {48'd0, mem_addr},    {48'd0, q[0].addr});
          chk("access_grant", {62'd0, grant_id},    64'(q[0].core));
          if (q[0].op == 2'b10) chk("access_wdata", {48'd0, mem_wdata}, {48'd0, q[0].wdata});
          if (q[0].req_cyc >= 0) chk("access_cycle", 64'(cyc), 64'(q[0].req_cyc + 1));
        end
      end
      if (core_ready != '0) begin
        chk("ready_one_cycle", {60'd0, prev_ready}, 64'd0);
        if (q.size() == 0) begin
          chk("unexpected_ready", {60'd0, core_ready}, 64'd0);
        end else begin
          em = q.pop_front();
          chk("ready_onehot", {60'd0, core_ready}, 64'(1 << em.core));
          chk("ready_not_aborted", 64'(em.abort), 64'd0);
          chk("ready_latency", 64'(cyc - em.acc_cyc), 64'd2);
          if (em.op == 2'b01) shadow[em.core*DW +: DW] = em.rdata;
          chk("core_rdata", core_rdata, shadow);
        end
      end
      prev_ready = core_ready;

      if (mc4 != 2'b00) begin
        if (q4.size() == 0) begin
          chk("lat4_unexpected_access", {62'd0, mc4}, 64'd0);
        end else begin
          q4[0].acc_cyc = cyc;
          chk("lat4_access_cycle", 64'(cyc), 64'(q4[0].req_cyc + 1));
          chk("lat4_access_op",    {62'd0, mc4}, {62'd0, q4[0].op});
          chk("lat4_access_addr",  {48'd0, ma4}, {48'd0, q4[0].addr});
        end
      end
      if (rdy4 != '0) begin
        if (q4.size() == 0) begin
          chk("lat4_unexpected_ready", {60'd0, rdy4}, 64'd0);
        end else begin
          em = q4.pop_front();
          chk("lat4_ready_onehot", {60'd0, rdy4}, 64'(1 << em.core));
          chk("lat4_ready_cycle",  64'(cyc), 64'(em.req_cyc + 6));
          shadow4[em.core*DW +: DW] = em.rdata;
          chk("lat4_core_rdata", rd4, shadow4);
        end
      end
    end
  end

  // Stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_core(input int c, input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    core_control[2*c +: 2] = op;
    core_addr[c*AW +: AW]  = a;
    core_wdata[c*DW +: DW] = d;
  endtask

  task automatic wait_ready(input int c, input bit on4);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (on4 ? rdy4[c] : core_ready[c]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_ready core %0d (lat4=%0d): got no core_ready in 40 cycles, expected a pulse", c, on4);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    core_control = '0;
    core_addr    = '0;
    core_wdata   = '0;
    ctl4         = '0;
    a4           = '0;
    w4           = '0;
    step(3);
    reset_n = 1'b1;
    step(2);

    // single read, core 2
    set_core(2, 2'b01, 16'h0010, 16'h0000);
    q.push_back(mk(2, 2'b01, 16'h0010, 16'h0000, cyc, 1'b0));
    wait_ready(2, 1'b0);
    set_core(2, 2'b00, 16'h0000, 16'h0000);
    step(2);

    // write, core 0
    set_core(0, 2'b10, 16'h0005, 16'h1234);
    q.push_back(mk(0, 2'b10, 16'h0005, 16'h1234, cyc, 1'b0));
    wait_ready(0, 1'b0);
    set_core(0, 2'b00, 16'h0000, 16'h0000);
    step(2);

    // latency-4 read, core 1
    ctl4[3:2]   = 2'b01;
    a4[31:16]   = 16'h0031;
    q4.push_back(mk(1, 2'b01, 16'h0031, 16'h0000, cyc, 1'b0));
    wait_ready(1, 1'b1);
    ctl4[3:2]   = 2'b00;
    step(2);

    // round robin after reset: all four request continuously
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    set_core(0, 2'b01, 16'h0020, 16'h0000);
    set_core(1, 2'b10, 16'h0021, 16'hA001);
    set_core(2, 2'b01, 16'h0022, 16'h0000);
    set_core(3, 2'b10, 16'h0023, 16'hA003);
    q.push_back(mk(0, 2'b01, 16'h0020, 16'h0000, cyc, 1'b0));
    q.push_back(mk(1, 2'b10, 16'h0021, 16'hA001, -1, 1'b0));
    q.push_back(mk(2, 2'b01, 16'h0022, 16'h0000, -1, 1'b0));
    q.push_back(mk(3, 2'b10, 16'h0023, 16'hA003, -1, 1'b0));
    q.push_back(mk(0, 2'b01, 16'h0020, 16'h0000, -1, 1'b0));
    wait_ready(0, 1'b0);
    wait_ready(1, 1'b0);
    wait_ready(2, 1'b0);
    wait_ready(3, 1'b0);
    for (int c = 1; c < 4; c++) set_core(c, 2'b00, 16'h0000, 16'h0000);
    wait_ready(0, 1'b0);
    set_core(0, 2'b00, 16'h0000, 16'h0000);
    step(2);

    // reserved command on core 1, address churn on core 3 during WAIT
    set_core(1, 2'b11, 16'h0999, 16'h5555);
    set_core(3, 2'b01, 16'h0040, 16'h0000);
    q.push_back(mk(3, 2'b01, 16'h0040, 16'h0000, cyc, 1'b0));
    step(2);
    set_core(3, 2'b01, 16'h0077, 16'h0000);
    wait_ready(3, 1'b0);
    set_core(3, 2'b00, 16'h0000, 16'h0000);
    step(8);
    set_core(1, 2'b00, 16'h0000, 16'h0000);
    step(2);

    // reset during WAIT aborts the read
    set_core(2, 2'b01, 16'h0012, 16'h0000);
    q.push_back(mk(2, 2'b01, 16'h0012, 16'h0000, cyc, 1'b1));
    step(2);
    reset_n = 1'b0;
    set_core(2, 2'b00, 16'h0000, 16'h0000);
    step(2);
    reset_n = 1'b1;
    set_core(1, 2'b01, 16'h0050, 16'h0000);
    set_core(3, 2'b01, 16'h0060, 16'h0000);
    q.push_back(mk(1, 2'b01, 16'h0050, 16'h0000, cyc, 1'b0));
    q.push_back(mk(3, 2'b01, 16'h0060, 16'h0000, -1, 1'b0));
    wait_ready(1, 1'b0);
    set_core(1, 2'b00, 16'h0000, 16'h0000);
    wait_ready(3, 1'b0);
    set_core(3, 2'b00, 16'h0000, 16'h0000);
    step(3);

    chk("scoreboard_drained", 64'(q.size() + q4.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
